dsp_host_ctrl: RTL and testbench

- Memory-mapped initiator for the DSP engine. The DSP engine is the responder: start/done handshake, 8x32-bit A/B operand arrays, 8x32-bit result array, 2-bit operation.
- The CPU-side bus writes operands and operation, then triggers GO. The block issues the start pulse, waits for done, latches results and raises an interrupt.
- Sits between the RISC-V core's peripheral bus and the DSP instance. Both share clk/rst.

---
 rtl/dsp_host_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dsp_host_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_host_ctrl.sv
// dsp_host_ctrl: memory-mapped initiator for the DSP engine.
// The CPU writes the A/B operands and the operation, then writes GO. The block
// pulses dsp_start, waits for dsp_done, captures the results and raises irq.
//
// Ports:
//   clk, rst          system clock (rising edge), async active-high reset
//   bus_we/bus_re     single-cycle write/read strobes
//   bus_addr          word address (5 bits)
//   bus_wdata         write data
//   bus_rdata         registered read data
//   bus_rvalid        high one cycle after an accepted read
//   irq               done_sticky & irq_en
//   dsp_start         one-cycle start pulse to the DSP
//   dsp_operation     00 add, 01 mul, 10 FIR, 11 sub
//   dsp_a, dsp_b      8-word operand arrays
//   dsp_result        8-word result array from the DSP
//   dsp_done          completion pulse from the DSP
//
// Optional build macro: DSP_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES.
module dsp_host_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bus_we,
  input  logic                   bus_re,
  input  logic [4:0]             bus_addr,
  input  logic [DATA_W-1:0]      bus_wdata,
  output logic [DATA_W-1:0]      bus_rdata,
  output logic                   bus_rvalid,
  output logic                   irq,
  output logic                   dsp_start,
  output logic [1:0]             dsp_operation,
  output logic [7:0][DATA_W-1:0] dsp_a,
  output logic [7:0][DATA_W-1:0] dsp_b,
  input  logic [7:0][DATA_W-1:0] dsp_result,
  input  logic                   dsp_done
);

  localparam logic [4:0] ADDR_CTRL = 5'h18;
  localparam logic [4:0] ADDR_STAT = 5'h19;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

  state_t state, state_nx;

  logic [7:0][DATA_W-1:0] a_q, b_q, res_q;
  logic [1:0]             op_q;
  logic                   irq_en_q;
  logic                   done_q;
  logic                   tmo_q;
  logic                   err_q;
  logic                   busy;

  logic wr_a, wr_b, wr_ctrl, wr_stat, go, capture, tmo_hit;
  logic [DATA_W-1:0] rd_mux;

  assign wr_a    = bus_we && (bus_addr[4:3] == 2'b00);
  assign wr_b    = bus_we && (bus_addr[4:3] == 2'b01);
  assign wr_ctrl = bus_we && (bus_addr == ADDR_CTRL);
  assign wr_stat = bus_we && (bus_addr == ADDR_STAT);
  assign go      = wr_ctrl && !busy && bus_wdata[8];
  assign capture = (state == ST_WAIT) && dsp_done;

`ifdef DSP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counter holds the number of completed WAIT cycles; the abort fires on the
  // last allowed one unless dsp_done arrives in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == ST_START)
      wait_cnt <= '0;
    else if (state == ST_WAIT)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign tmo_hit = (state == ST_WAIT) && !dsp_done &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (go) state_nx = ST_START;
      ST_START: state_nx = ST_WAIT;
      ST_WAIT:  if (capture || tmo_hit) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    dsp_start = 1'b0;
    busy      = 1'b1;
    unique case (state)
      ST_IDLE:  busy = 1'b0;
      ST_START: dsp_start = 1'b1;
      default:  ;
    endcase
  end

  assign dsp_a         = a_q;
  assign dsp_b         = b_q;
  assign dsp_operation = op_q;
  assign irq           = done_q & irq_en_q;

  // Read mux sees pre-edge register values, so a read in the capture cycle
  // returns the pre-capture STATUS.
  always_comb begin
    rd_mux = '0;
    unique case (bus_addr[4:3])
      2'b00: rd_mux = a_q[bus_addr[2:0]];
      2'b01: rd_mux = b_q[bus_addr[2:0]];
      2'b10: rd_mux = res_q[bus_addr[2:0]];
      default: begin
        if (bus_addr == ADDR_CTRL) begin
          rd_mux[1:0] = op_q;
          rd_mux[4]   = irq_en_q;
        end else if (bus_addr == ADDR_STAT) begin
          rd_mux[3:0] = {err_q, tmo_q, done_q, busy};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      op_q       <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      if (!busy) begin
        if (wr_a) a_q[bus_addr[2:0]] <= bus_wdata;
        if (wr_b) b_q[bus_addr[2:0]] <= bus_wdata;
        if (wr_ctrl) begin
          op_q     <= bus_wdata[1:0];
          irq_en_q <= bus_wdata[4];
        end
      end else if (wr_a || wr_b || wr_ctrl) begin
        err_q <= 1'b1;
      end

      if (wr_stat && bus_wdata[3]) err_q <= 1'b0;

      // Completion beats a same-cycle W1C of done_sticky.
      if (capture || tmo_hit)
        done_q <= 1'b1;
      else if (go || (wr_stat && bus_wdata[1]))
        done_q <= 1'b0;

      if (tmo_hit)
        tmo_q <= 1'b1;
      else if (go || (wr_stat && bus_wdata[2]))
        tmo_q <= 1'b0;

      if (capture) res_q <= dsp_result;

      // A simultaneous write wins; the read is dropped.
      bus_rvalid <= bus_re && !bus_we;
      if (bus_re && !bus_we) bus_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_dsp_host_ctrl.sv
module tb_dsp_host_ctrl;

`ifdef DSP_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 256;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bus_we = 1'b0;
  logic              bus_re = 1'b0;
  logic [4:0]        bus_addr = '0;
  logic [31:0]       bus_wdata = '0;
  logic [31:0]       bus_rdata;
  logic              bus_rvalid;
  logic              irq;
  logic              dsp_start;
  logic [1:0]        dsp_operation;
  logic [7:0][31:0]  dsp_a;
  logic [7:0][31:0]  dsp_b;
  logic [7:0][31:0]  dsp_result = '0;
  logic              dsp_done = 1'b0;

  int tests = 0;
  int failed = 0;
  int start_cnt = 0;
  int s0;
  logic [31:0] rd;

  dsp_host_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .irq(irq), .dsp_start(dsp_start), .dsp_operation(dsp_operation),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_result(dsp_result), .dsp_done(dsp_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dsp_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus_re = 1'b1; bus_addr = addr;
    @(negedge clk);
    bus_re = 1'b0;
    data = bus_rdata;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    dsp_done = 1'b1;
    @(negedge clk);
    dsp_done = 1'b0;
  endtask

  initial begin
    // Reset and sweep every mapped address plus one unmapped address
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 26; a++) begin
      bus_read(5'(a), rd);
      check($sformatf("reset_rd_%0d", a), rd, 32'h0);
    end
    bus_read(5'h1F, rd);
    check("unmapped_rd", rd, 32'h0);
    check("reset_rvalid", {31'b0, bus_rvalid}, 32'h1);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_no_start", start_cnt, 0);

    // Add: A[i]=i+1, B[i]=10 -> RES[i]=11+i
    for (int i = 0; i < 8; i++) begin
      bus_write(5'(i), 32'(i + 1));
      bus_write(5'(8 + i), 32'd10);
      dsp_result[i] = 32'(11 + i);
    end
    bus_write(5'h18, 32'h100);
    check("add_start_hi", {31'b0, dsp_start}, 32'h1);
    repeat (8) @(negedge clk);
    check("add_start_once", start_cnt, 1);
    bus_read(5'h19, rd);
    check("add_busy", rd, 32'h1);
    repeat (8) @(negedge clk);
    pulse_done();
    for (int i = 0; i < 8; i++) begin
      bus_read(5'(16 + i), rd);
      check($sformatf("add_res_%0d", i), rd, 32'(11 + i));
    end
    bus_read(5'h19, rd);
    check("add_status", rd, 32'h2);
    check("add_irq", {31'b0, irq}, 32'h0);
    bus_read(5'h18, rd);
    check("add_ctrl_rd", rd, 32'h0);

    // Mul with irq_en; W1C of done in the capture cycle must lose
    for (int i = 0; i < 8; i++) begin
      bus_write(5'(i), 32'd3);
      bus_write(5'(8 + i), 32'(i));
      dsp_result[i] = 32'(3 * i);
    end
    bus_write(5'h18, 32'h111);
    check("mul_op_out", {30'b0, dsp_operation}, 32'h1);
    check("mul_a2_out", dsp_a[2], 32'd3);
    check("mul_b5_out", dsp_b[5], 32'd5);
    check("mul_irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(5'h19, rd);
    check("mul_busy", rd, 32'h1);
    @(negedge clk);
    dsp_done = 1'b1; bus_we = 1'b1; bus_addr = 5'h19; bus_wdata = 32'h2;
    @(negedge clk);
    dsp_done = 1'b0; bus_we = 1'b0;
    check("mul_irq", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      bus_read(5'(16 + i), rd);
      check($sformatf("mul_res_%0d", i), rd, 32'(3 * i));
    end
    bus_read(5'h18, rd);
    check("mul_ctrl_rd", rd, 32'h11);
    bus_write(5'h19, 32'h2);
    check("mul_w1c_irq", {31'b0, irq}, 32'h0);
    bus_read(5'h19, rd);
    check("mul_w1c_status", rd, 32'h0);

    // Simultaneous write and read: write wins, no rvalid
    @(negedge clk);
    bus_we = 1'b1; bus_re = 1'b1; bus_addr = 5'h01; bus_wdata = 32'h77;
    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    check("wr_rd_rvalid", {31'b0, bus_rvalid}, 32'h0);
    bus_read(5'h01, rd);
    check("wr_rd_data", rd, 32'h77);

    // Writes while busy are dropped and flag err; STATUS read in capture cycle
    for (int i = 0; i < 8; i++) dsp_result[i] = 32'(8'h55 + i);
    s0 = start_cnt;
    bus_write(5'h18, 32'h100);
    bus_write(5'h00, 32'hDEAD);
    bus_write(5'h18, 32'h100);
    repeat (3) @(negedge clk);
    check("busy_one_start", start_cnt, s0 + 1);
    @(negedge clk);
    dsp_done = 1'b1; bus_re = 1'b1; bus_addr = 5'h19;
    @(negedge clk);
    dsp_done = 1'b0; bus_re = 1'b0;
    check("capture_rd_status", bus_rdata, 32'h9);
    bus_read(5'h00, rd);
    check("busy_a0_kept", rd, 32'd3);
    bus_read(5'h10, rd);
    check("busy_res0", rd, 32'h55);
    bus_read(5'h19, rd);
    check("busy_status", rd, 32'hA);
    bus_write(5'h19, 32'h8);
    bus_read(5'h19, rd);
    check("err_w1c", rd, 32'h2);

`ifdef DSP_TIMEOUT_EN
    // Watchdog: never answer; abort sets timeout and done, RES untouched
    bus_write(5'h18, 32'h100);
    repeat (6) @(negedge clk);
    bus_read(5'h19, rd);
    check("tmo_busy", rd, 32'h1);
    repeat (20) @(negedge clk);
    bus_read(5'h19, rd);
    check("tmo_status", rd, 32'h6);
    bus_read(5'h11, rd);
    check("tmo_res1", rd, 32'h56);
    s0 = start_cnt;
    bus_write(5'h18, 32'h100);
    repeat (2) @(negedge clk);
    check("tmo_rego", start_cnt, s0 + 1);
    pulse_done();
    bus_read(5'h19, rd);
    check("tmo_rego_status", rd, 32'h2);
`else
    check("no_tmo_bit", {31'b0, rd[2]}, 32'h0);
`endif

    // Reset in WAIT; a late dsp_done is ignored
    bus_write(5'h18, 32'h111);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_start_lo", {31'b0, dsp_start}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(5'h19, rd);
    check("rst_status", rd, 32'h0);
    bus_read(5'h00, rd);
    check("rst_a0", rd, 32'h0);
    bus_read(5'h10, rd);
    check("rst_res0", rd, 32'h0);
    bus_read(5'h18, rd);
    check("rst_ctrl", rd, 32'h0);
    pulse_done();
    bus_read(5'h19, rd);
    check("late_done_ignored", rd, 32'h0);
    check("late_done_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
